mem_stage: RTL and testbench

//  MEM stage of the IF1-IF2-ID-EX-MEM-WB pipeline. Holds the EX/MEM register and drives the synchronous data-memory port.

---
 rtl/mem_stage.sv | 203 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
//==============================================================================
// mem_stage : EX/MEM and MEM/WB pipeline registers, store lane alignment,
//             data-memory port and load-data extraction.
// Revision  : 1.0
//==============================================================================
`default_nettype none

package mem_stage_pkg;
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH          = 32,
  parameter int DATA_MEM_ADDR_WIDTH = 12
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush_i,
  input  logic                           valid_i,
  input  logic [DATA_WIDTH-1:0]          alu_result_i,
  input  logic [DATA_WIDTH-1:0]          rs2_data_i,
  input  logic [2:0]                     funct3_i,
  input  logic [4:0]                     rd_addr_i,
  input  logic                           MemWrite_i,
  input  logic                           MemRead_i,
  input  logic                           RegWrite_i,
  input  wb_sel_e                        WBSel_i,
  input  logic [DATA_WIDTH-1:0]          pc_plus4_i,
  output logic [DATA_MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]          mem_wrdata_o,
  output logic [3:0]                     mem_be_o,
  output logic                           mem_we_o,
  input  logic [DATA_WIDTH-1:0]          mem_rdata_i,
  output logic [4:0]                     mem_rd_addr_o,
  output logic                           mem_RegWrite_o,
  output logic [DATA_WIDTH-1:0]          mem_alu_result_o,
  output logic                           wb_valid_o,
  output logic [4:0]                     wb_rd_addr_o,
  output logic                           wb_RegWrite_o,
  output wb_sel_e                        wb_WBSel_o,
  output logic [DATA_WIDTH-1:0]          wb_alu_result_o,
  output logic [DATA_WIDTH-1:0]          wb_pc_plus4_o,
  output logic [DATA_WIDTH-1:0]          wb_load_data_o,
  output logic                           wb_fault_o
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] alu;
    logic [DATA_WIDTH-1:0] rs2;
    logic [2:0]            funct3;
    logic [4:0]            rd;
    logic                  mem_write;
    logic                  mem_read;
    logic                  reg_write;
    wb_sel_e               wb_sel;
    logic [DATA_WIDTH-1:0] pc4;
  } ex_mem_t;

  typedef struct packed {
    logic                  valid;
    logic [4:0]            rd;
    logic                  reg_write;
    logic                  mem_read;
    wb_sel_e               wb_sel;
    logic [DATA_WIDTH-1:0] alu;
    logic [DATA_WIDTH-1:0] pc4;
    logic [2:0]            funct3;
    logic [1:0]            off;
    logic                  fault;
  } mem_wb_t;

  ex_mem_t               ex_mem_d, ex_mem_q;
  mem_wb_t               mem_wb_d, mem_wb_q;
  logic [1:0]            off;
  logic                  ld_legal, st_legal, misalign, fault;
  logic [3:0]            be_raw;
  logic [DATA_WIDTH-1:0] wrdata;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;

  always_comb begin
    ex_mem_d = '{valid: valid_i, alu: alu_result_i, rs2: rs2_data_i, funct3: funct3_i,
                 rd: rd_addr_i, mem_write: MemWrite_i, mem_read: MemRead_i,
                 reg_write: RegWrite_i, wb_sel: WBSel_i, pc4: pc_plus4_i};
    if (flush_i) begin
      ex_mem_d.valid     = 1'b0;
      ex_mem_d.mem_write = 1'b0;
      ex_mem_d.mem_read  = 1'b0;
      ex_mem_d.reg_write = 1'b0;
    end
  end

  assign off = ex_mem_q.alu[1:0];

  // Size decode drives both lane steering and legality/alignment checks.
  always_comb begin
    ld_legal = 1'b0;
    st_legal = 1'b0;
    misalign = 1'b0;
    be_raw   = 4'b1111;
    wrdata   = ex_mem_q.rs2;
    case (ex_mem_q.funct3)
      F3_B: begin
        ld_legal = 1'b1;
        st_legal = 1'b1;
        be_raw   = 4'b0001 << off;
        wrdata   = {4{ex_mem_q.rs2[7:0]}};
      end
      F3_H: begin
        ld_legal = 1'b1;
        st_legal = 1'b1;
        misalign = off[0];
        be_raw   = 4'b0011 << off;
        wrdata   = {2{ex_mem_q.rs2[15:0]}};
      end
      F3_W: begin
        ld_legal = 1'b1;
        st_legal = 1'b1;
        misalign = (off != 2'b00);
      end
      F3_BU: ld_legal = 1'b1;
      F3_HU: begin
        ld_legal = 1'b1;
        misalign = off[0];
      end
      default: ;
    endcase
    fault = (ex_mem_q.mem_read | ex_mem_q.mem_write) &
            (misalign | (ex_mem_q.mem_read & ~ld_legal) | (ex_mem_q.mem_write & ~st_legal));
  end

  assign mem_addr_o       = ex_mem_q.alu[DATA_MEM_ADDR_WIDTH+1:2];
  assign mem_wrdata_o     = wrdata;
  assign mem_we_o         = ex_mem_q.valid & ex_mem_q.mem_write & ~fault;
  assign mem_be_o         = mem_we_o ? be_raw : 4'b0000;
  assign mem_rd_addr_o    = ex_mem_q.rd;
  assign mem_RegWrite_o   = ex_mem_q.valid & ex_mem_q.reg_write;
  assign mem_alu_result_o = ex_mem_q.alu;

  always_comb begin
    mem_wb_d = '{valid: ex_mem_q.valid, rd: ex_mem_q.rd,
                 reg_write: ex_mem_q.valid & ex_mem_q.reg_write & ~(ex_mem_q.mem_read & fault),
                 mem_read: ex_mem_q.valid & ex_mem_q.mem_read, wb_sel: ex_mem_q.wb_sel,
                 alu: ex_mem_q.alu, pc4: ex_mem_q.pc4, funct3: ex_mem_q.funct3,
                 off: off, fault: fault};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign wb_valid_o      = mem_wb_q.valid;
  assign wb_rd_addr_o    = mem_wb_q.rd;
  assign wb_RegWrite_o   = mem_wb_q.reg_write;
  assign wb_WBSel_o      = mem_wb_q.wb_sel;
  assign wb_alu_result_o = mem_wb_q.alu;
  assign wb_pc_plus4_o   = mem_wb_q.pc4;
  assign wb_fault_o      = mem_wb_q.fault;

  // Read data arrives one cycle after the address, so extraction uses the WB copy of funct3/off.
  always_comb begin
    case (mem_wb_q.off)
      2'd0:    ld_byte = mem_rdata_i[7:0];
      2'd1:    ld_byte = mem_rdata_i[15:8];
      2'd2:    ld_byte = mem_rdata_i[23:16];
      default: ld_byte = mem_rdata_i[31:24];
    endcase
    ld_half        = mem_wb_q.off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    wb_load_data_o = '0;
    if (mem_wb_q.mem_read && !mem_wb_q.fault) begin
      case (mem_wb_q.funct3)
        F3_B:    wb_load_data_o = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
        F3_BU:   wb_load_data_o = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
        F3_H:    wb_load_data_o = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
        F3_HU:   wb_load_data_o = {{(DATA_WIDTH-16){1'b0}}, ld_half};
        F3_W:    wb_load_data_o = mem_rdata_i;
        default: wb_load_data_o = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
//==============================================================================
// tb_mem_stage : self-checking bench for mem_stage with a byte-level memory
//                reference model.
// Revision     : 1.0
//==============================================================================
`default_nettype none

module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int DMAW = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i, valid_i;
  logic [31:0] alu_result_i, rs2_data_i, pc_plus4_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_addr_i;
  logic        MemWrite_i, MemRead_i, RegWrite_i;
  wb_sel_e     WBSel_i;
  logic [DMAW-1:0] mem_addr_o;
  logic [31:0] mem_wrdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_we_o;
  logic [31:0] mem_rdata_i = 32'h0;
  logic [4:0]  mem_rd_addr_o;
  logic        mem_RegWrite_o;
  logic [31:0] mem_alu_result_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_addr_o;
  logic        wb_RegWrite_o;
  wb_sel_e     wb_WBSel_o;
  logic [31:0] wb_alu_result_o, wb_pc_plus4_o, wb_load_data_o;
  logic        wb_fault_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.DATA_WIDTH(32), .DATA_MEM_ADDR_WIDTH(DMAW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i),
    .alu_result_i(alu_result_i), .rs2_data_i(rs2_data_i), .funct3_i(funct3_i),
    .rd_addr_i(rd_addr_i), .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i),
    .RegWrite_i(RegWrite_i), .WBSel_i(WBSel_i), .pc_plus4_i(pc_plus4_i),
    .mem_addr_o(mem_addr_o), .mem_wrdata_o(mem_wrdata_o), .mem_be_o(mem_be_o),
    .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i), .mem_rd_addr_o(mem_rd_addr_o),
    .mem_RegWrite_o(mem_RegWrite_o), .mem_alu_result_o(mem_alu_result_o),
    .wb_valid_o(wb_valid_o), .wb_rd_addr_o(wb_rd_addr_o), .wb_RegWrite_o(wb_RegWrite_o),
    .wb_WBSel_o(wb_WBSel_o), .wb_alu_result_o(wb_alu_result_o),
    .wb_pc_plus4_o(wb_pc_plus4_o), .wb_load_data_o(wb_load_data_o), .wb_fault_o(wb_fault_o)
  );

  // Synchronous data memory attached to the DUT port.
  logic [31:0] dmem [0:4095] = '{default: 32'h0};

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] w;
    w = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = new_w[8*b +: 8];
    return w;
  endfunction

  always @(posedge clk) begin
    if (mem_we_o) dmem[mem_addr_o] <= merge_lanes(dmem[mem_addr_o], mem_wrdata_o, mem_be_o);
    mem_rdata_i <= dmem[mem_addr_o];
  end

  // Reference model: byte-addressed memory plus expected WB view of the previous instruction.
  logic [7:0]  ref_bytes [0:16383] = '{default: 8'h0};
  bit          pend_st;
  logic [31:0] pend_addr, pend_data;
  int          pend_size;
  bit          p_valid, p_rw, p_fault;
  logic [4:0]  p_rd;
  wb_sel_e     p_sel;
  logic [31:0] p_alu, p_pc4, p_ld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    pend_st = 1'b0;
    p_valid = 1'b0; p_rw = 1'b0; p_fault = 1'b0;
    p_rd = 5'd0; p_sel = WB_ALU; p_alu = 32'h0; p_pc4 = 32'h0; p_ld = 32'h0;
  endtask

  task automatic step(input bit v, input bit fl, input bit mw, input bit mr, input bit rw,
                      input wb_sel_e sel, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] rs2, input logic [4:0] rd, input logic [31:0] pc4);
    bit live, e_mw, e_mr, e_rw, legal, fault, we;
    int size;
    logic [3:0]  be;
    logic [31:0] wr, ld;
    valid_i = v; flush_i = fl; MemWrite_i = mw; MemRead_i = mr; RegWrite_i = rw;
    WBSel_i = sel; funct3_i = f3; alu_result_i = addr; rs2_data_i = rs2;
    rd_addr_i = rd; pc_plus4_i = pc4;

    if (pend_st) begin
      for (int i = 0; i < pend_size; i++) ref_bytes[(pend_addr + i) & 16383] = pend_data[8*i +: 8];
      pend_st = 1'b0;
    end
    live  = v && !fl;
    e_mw  = live && mw;
    e_mr  = live && mr;
    e_rw  = live && rw;
    size  = 1 << f3[1:0];
    legal = e_mr ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    fault = (e_mr || e_mw) && (!legal || (addr % 32'(size)) != 0);
    we    = e_mw && !fault;
    be    = we ? 4'(((1 << size) - 1) << addr[1:0]) : 4'b0000;
    wr    = (size == 1) ? rs2[7:0] * 32'h01010101 : (size == 2) ? rs2[15:0] * 32'h00010001 : rs2;
    ld    = 32'h0;
    if (e_mr && !fault) begin
      for (int i = 0; i < size; i++) ld[8*i +: 8] = ref_bytes[(addr + i) & 16383];
      if (!f3[2] && size < 4 && ld[8*size-1]) ld = ld | ~((32'd1 << (8*size)) - 1);
    end
    if (we) begin
      pend_st = 1'b1; pend_addr = addr; pend_data = rs2; pend_size = size;
    end

    @(posedge clk);
    #1;
    chk("mem_addr", 32'(mem_addr_o), 32'(addr[13:2]));
    chk("mem_we", 32'(mem_we_o), 32'(we));
    chk("mem_be", 32'(mem_be_o), 32'(be));
    if (we) chk("mem_wrdata", mem_wrdata_o, wr);
    chk("mem_RegWrite", 32'(mem_RegWrite_o), 32'(e_rw));
    chk("mem_rd", 32'(mem_rd_addr_o), 32'(rd));
    chk("mem_alu", mem_alu_result_o, addr);
    chk("wb_valid", 32'(wb_valid_o), 32'(p_valid));
    chk("wb_RegWrite", 32'(wb_RegWrite_o), 32'(p_rw));
    chk("wb_fault", 32'(wb_fault_o), 32'(p_fault));
    chk("wb_load_data", wb_load_data_o, p_ld);
    chk("wb_rd", 32'(wb_rd_addr_o), 32'(p_rd));
    chk("wb_WBSel", 32'(wb_WBSel_o), 32'(p_sel));
    chk("wb_alu", wb_alu_result_o, p_alu);
    chk("wb_pc4", wb_pc_plus4_o, p_pc4);

    p_valid = live; p_rw = e_rw && !(e_mr && fault); p_fault = fault; p_ld = ld;
    p_rd = rd; p_sel = sel; p_alu = addr; p_pc4 = pc4;
  endtask

  task automatic do_st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d, input bit fl);
    step(1'b1, fl, 1'b1, 1'b0, 1'b0, WB_ALU, f3, a, d, 5'($urandom), $urandom);
  endtask

  task automatic do_ld(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd, input bit fl);
    step(1'b1, fl, 1'b0, 1'b1, 1'b1, WB_MEM, f3, a, $urandom, rd, $urandom);
  endtask

  task automatic bubble();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, WB_ALU, 3'($urandom), $urandom, $urandom, 5'($urandom), $urandom);
  endtask

  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mem_we", 32'(mem_we_o), 32'h0);
    chk("rst_mem_be", 32'(mem_be_o), 32'h0);
    chk("rst_wb_valid", 32'(wb_valid_o), 32'h0);
    chk("rst_wb_RegWrite", 32'(wb_RegWrite_o), 32'h0);
    chk("rst_mem_RegWrite", 32'(mem_RegWrite_o), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    logic [31:0] a;
    int op;
    rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; alu_result_i = 32'h0; rs2_data_i = 32'h0;
    funct3_i = 3'd0; rd_addr_i = 5'd0; MemWrite_i = 1'b0; MemRead_i = 1'b0; RegWrite_i = 1'b0;
    WBSel_i = WB_ALU; pc_plus4_i = 32'h0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mem_we", 32'(mem_we_o), 32'h0);
    chk("reset_mem_be", 32'(mem_be_o), 32'h0);
    chk("reset_mem_addr", 32'(mem_addr_o), 32'h0);
    chk("reset_mem_RegWrite", 32'(mem_RegWrite_o), 32'h0);
    chk("reset_wb_valid", 32'(wb_valid_o), 32'h0);
    chk("reset_wb_RegWrite", 32'(wb_RegWrite_o), 32'h0);
    chk("reset_wb_fault", 32'(wb_fault_o), 32'h0);
    chk("reset_wb_load", wb_load_data_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store then load of the same word.
    do_st(3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
    chk("t1_addr", 32'(mem_addr_o), 32'd4);
    chk("t1_be", 32'(mem_be_o), 32'hF);
    chk("t1_we", 32'(mem_we_o), 32'd1);
    do_ld(3'b010, 32'h10, 5'd5, 1'b0);
    bubble();
    chk("t1_load", wb_load_data_o, 32'hDEADBEEF);
    chk("t1_regwrite", 32'(wb_RegWrite_o), 32'd1);

    // Byte store lanes and signed/unsigned byte loads.
    do_st(3'b000, 32'h22, 32'h000000A5, 1'b0);
    chk("t2_addr", 32'(mem_addr_o), 32'd8);
    chk("t2_be", 32'(mem_be_o), 32'h4);
    chk("t2_wrdata", mem_wrdata_o, 32'hA5A5A5A5);
    do_st(3'b010, 32'h20, 32'h00800000, 1'b0);
    do_ld(3'b000, 32'h22, 5'd6, 1'b0);
    do_ld(3'b100, 32'h22, 5'd7, 1'b0);
    chk("t2_lb", wb_load_data_o, 32'hFFFFFF80);
    bubble();
    chk("t2_lbu", wb_load_data_o, 32'h00000080);

    // Misaligned accesses fault and never write.
    do_st(3'b001, 32'h13, 32'h00001234, 1'b0);
    chk("t3_we", 32'(mem_we_o), 32'd0);
    chk("t3_be", 32'(mem_be_o), 32'd0);
    do_ld(3'b010, 32'h12, 5'd8, 1'b0);
    chk("t3_sh_fault", 32'(wb_fault_o), 32'd1);
    bubble();
    chk("t3_lw_fault", 32'(wb_fault_o), 32'd1);
    chk("t3_lw_regwrite", 32'(wb_RegWrite_o), 32'd0);
    chk("t3_lw_data", wb_load_data_o, 32'h0);

    // Upper halfword loads.
    do_st(3'b010, 32'h04, 32'h9ABC1234, 1'b0);
    do_ld(3'b101, 32'h06, 5'd9, 1'b0);
    do_ld(3'b001, 32'h06, 5'd10, 1'b0);
    chk("t4_lhu", wb_load_data_o, 32'h00009ABC);
    bubble();
    chk("t4_lh", wb_load_data_o, 32'hFFFF9ABC);

    // Flushed store and load.
    do_st(3'b010, 32'h30, 32'hCAFEF00D, 1'b1);
    chk("t5_we", 32'(mem_we_o), 32'd0);
    do_ld(3'b010, 32'h30, 5'd11, 1'b1);
    chk("t5_mem_regwrite", 32'(mem_RegWrite_o), 32'd0);
    chk("t5_wb_valid", 32'(wb_valid_o), 32'd0);
    do_ld(3'b010, 32'h30, 5'd12, 1'b0);
    bubble();
    chk("t5_not_written", wb_load_data_o, 32'h0);

    // Asynchronous reset while a store sits in MEM.
    do_st(3'b010, 32'h40, 32'h11112222, 1'b0);
    chk("t6_we_before", 32'(mem_we_o), 32'd1);
    mid_reset();
    do_ld(3'b010, 32'h40, 5'd13, 1'b0);
    bubble();
    chk("t6_no_partial_write", wb_load_data_o, 32'h0);

    // Randomized mix checked against the reference model.
    for (int n = 0; n < 400; n++) begin
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFFC000);
      op = $urandom_range(0, 4);
      case (op)
        0: do_st(($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 2)) : 3'($urandom), a,
                 $urandom, ($urandom_range(0, 7) == 0));
        1: do_ld(3'($urandom), a, 5'($urandom), ($urandom_range(0, 7) == 0));
        2: step(1'b1, ($urandom_range(0, 7) == 0), 1'b0, 1'b0, 1'b1, WB_ALU, 3'($urandom), a,
                $urandom, 5'($urandom), $urandom);
        3: bubble();
        default: step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, WB_PC4, 3'($urandom), a, $urandom,
                      5'($urandom), $urandom);
      endcase
    end
    bubble();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
